// File: rtl/fdma_pkg.sv
// Shared FDMA definitions used by the write engine and the read engine.
// Holds the beat geometry, the fixed AXI encodings, the 4 KB boundary and the
// write-engine state type.
package fdma_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 128;
    localparam int unsigned BPB            = DATA_WIDTH_DEF / 8;
    localparam int unsigned BOUNDARY_4K    = 4096;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    // Bufferable + modifiable, no allocate hints.
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StAw,
        StW,
        StB
    } fdma_wr_state_t;

endpackage

// File: rtl/fdma_axi_wr_if.sv
// Signal bundle between the FDMA write engine, the controller's write FIFO and
// the AXI4 write channels.
//   master : engine side (drives AW/W/B-ready and FDMA status)
//   slave  : controller + AXI slave side
interface fdma_axi_wr_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128
);

    // Controller request / FIFO side
    logic [ADDR_WIDTH-1:0]   fdma_waddr;
    logic                    fdma_wareq;
    logic [15:0]             fdma_wsize;
    logic                    fdma_wbusy;
    logic [DATA_WIDTH-1:0]   fdma_wdata;
    logic                    fdma_wready;
    logic                    fdma_wvalid;
    logic                    fdma_werr;

    // AXI4 write address channel
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic [3:0]              m_axi_awcache;
    logic [2:0]              m_axi_awprot;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;

    // AXI4 write data channel
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;

    // AXI4 write response channel
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        input  fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata, fdma_wready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output fdma_wbusy, fdma_wvalid, fdma_werr,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready
    );

    modport slave (
        output fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata, fdma_wready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  fdma_wbusy, fdma_wvalid, fdma_werr,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready
    );

endinterface

// File: rtl/fdma_burst_len.sv
// Burst length calculator shared by the FDMA read and write engines.
// o_len = min(i_remain, MAX_BURST_LEN, beats left before the next 4 KB line).
// Ports:
//   i_addr_lo : byte address bits [11:0] of the next burst (beat aligned)
//   i_remain  : beats still to transfer
//   o_len     : beats in the next burst (1..MAX_BURST_LEN when i_remain > 0)
module fdma_burst_len
    import fdma_pkg::*;
#(
    parameter int unsigned MAX_BURST_LEN  = 256,
    parameter int unsigned BYTES_PER_BEAT = BPB
) (
    input  logic [11:0] i_addr_lo,
    input  logic [15:0] i_remain,
    output logic [8:0]  o_len
);

    localparam int unsigned LP_SHIFT = $clog2(BYTES_PER_BEAT);
    localparam logic [12:0] LP_4K    = 13'(BOUNDARY_4K);
    localparam logic [15:0] LP_MAX   = 16'(MAX_BURST_LEN);

    logic [12:0] w_room_bytes;
    logic [12:0] w_room_beats;
    logic [15:0] w_min;

    always_comb begin
        w_room_bytes = LP_4K - {1'b0, i_addr_lo};
        w_room_beats = w_room_bytes >> LP_SHIFT;
        w_min        = i_remain;
        if ({3'b000, w_room_beats} < w_min) begin
            w_min = {3'b000, w_room_beats};
        end
        if (LP_MAX < w_min) begin
            w_min = LP_MAX;
        end
        o_len = w_min[8:0];
    end

endmodule

// File: rtl/fdma_axi_wr.sv
// FDMA write engine: turns one line-segment request (address, beat count) into
// a sequence of AXI4 INCR write bursts, one burst outstanding at a time, each
// capped at MAX_BURST_LEN beats and never crossing a 4 KB line.
// Ports:
//   ui_clk : clock
//   ui_rst : asynchronous active-high reset
//   bus    : request, FIFO and AXI4 write channels (fdma_axi_wr_if.master)
module fdma_axi_wr
    import fdma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned MAX_BURST_LEN = 256
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    fdma_axi_wr_if.master       bus
);

    localparam int unsigned LP_BPB   = DATA_WIDTH / 8;
    localparam int unsigned LP_SHIFT = $clog2(LP_BPB);
    localparam logic [ADDR_WIDTH-1:0] LP_ALIGN_MASK = ~ADDR_WIDTH'(LP_BPB - 1);

    fdma_wr_state_t          r_state, w_state_d;
    logic [ADDR_WIDTH-1:0]   r_cur_addr, w_cur_addr_d;
    logic [15:0]             r_remain, w_remain_d;
    logic [7:0]              r_beat_cnt, w_beat_cnt_d;
    logic                    r_busy, w_busy_d;
    logic                    r_werr, w_werr_d;

    logic [8:0]              w_len;
    logic [8:0]              w_len_m1;
    logic                    w_wvalid;
    logic                    w_w_hs;

    // cur_addr/remain stay constant from AW until the last beat, so the
    // length seen in AW is the one used for beat_cnt and for the update.
    fdma_burst_len #(
        .MAX_BURST_LEN  (MAX_BURST_LEN),
        .BYTES_PER_BEAT (LP_BPB)
    ) u_burst_len (
        .i_addr_lo (r_cur_addr[11:0]),
        .i_remain  (r_remain),
        .o_len     (w_len)
    );

    assign w_len_m1 = w_len - 9'd1;
    assign w_wvalid = (r_state == StW) & bus.fdma_wready;
    assign w_w_hs   = w_wvalid & bus.m_axi_wready;

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_state    <= StIdle;
            r_cur_addr <= '0;
            r_remain   <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_werr     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cur_addr <= w_cur_addr_d;
            r_remain   <= w_remain_d;
            r_beat_cnt <= w_beat_cnt_d;
            r_busy     <= w_busy_d;
            r_werr     <= w_werr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cur_addr_d = r_cur_addr;
        w_remain_d   = r_remain;
        w_beat_cnt_d = r_beat_cnt;
        w_busy_d     = r_busy;
        w_werr_d     = r_werr;

        case (r_state)
            StIdle: begin
                // A zero-length request still produces a one-cycle busy pulse.
                w_busy_d = bus.fdma_wareq;
                if (bus.fdma_wareq && (bus.fdma_wsize != 16'd0)) begin
                    w_cur_addr_d = bus.fdma_waddr & LP_ALIGN_MASK;
                    w_remain_d   = bus.fdma_wsize;
                    w_werr_d     = 1'b0;
                    w_state_d    = StAw;
                end
            end
            StAw: begin
                if (bus.m_axi_awready) begin
                    w_beat_cnt_d = w_len_m1[7:0];
                    w_state_d    = StW;
                end
            end
            StW: begin
                if (w_w_hs) begin
                    if (r_beat_cnt == 8'd0) begin
                        w_remain_d   = r_remain - {7'd0, w_len};
                        w_cur_addr_d = r_cur_addr + (ADDR_WIDTH'(w_len) << LP_SHIFT);
                        w_state_d    = StB;
                    end else begin
                        w_beat_cnt_d = r_beat_cnt - 8'd1;
                    end
                end
            end
            StB: begin
                if (bus.m_axi_bvalid) begin
                    if (bus.m_axi_bresp != AXI_RESP_OKAY) begin
                        w_werr_d = 1'b1;
                    end
                    if (r_remain != 16'd0) begin
                        w_state_d = StAw;
                    end else begin
                        w_state_d = StIdle;
                        w_busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // Control outputs decode the async-reset state, so they drop immediately
    // on ui_rst.
    assign bus.m_axi_awaddr  = r_cur_addr;
    assign bus.m_axi_awlen   = (r_state == StAw) ? w_len_m1[7:0] : 8'd0;
    assign bus.m_axi_awsize  = 3'(LP_SHIFT);
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_awcache = AXI_CACHE_BUF;
    assign bus.m_axi_awprot  = AXI_PROT_NONE;
    assign bus.m_axi_awvalid = (r_state == StAw);

    assign bus.m_axi_wdata   = bus.fdma_wdata;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wvalid  = w_wvalid;
    assign bus.m_axi_wlast   = (r_state == StW) & (r_beat_cnt == 8'd0);

    assign bus.m_axi_bready  = (r_state == StB);

    assign bus.fdma_wvalid   = w_w_hs;
    assign bus.fdma_wbusy    = r_busy;
    assign bus.fdma_werr     = r_werr;

endmodule
